rx_channel: RTL and testbench

- Receive-side stage directly downstream of the transmit channel.
- Consumes the VALID/READY/xDATA handshake on the bus and buffers accepted beats in a DEPTH-entry FIFO.
- Presents the head beat to the local data sink as a first-word-fall-through interface.
- Monitors the bus for AXI stability violations by the transmitter and flags them with a sticky error.

---
 rtl/rx_channel.sv | 75 +++++++
 tb/tb_rx_channel.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_channel.sv
// rx_channel: bus receive stage buffering accepted beats in a FWFT FIFO, with a sticky stability monitor
module rx_channel #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       VALID,
    output logic                       READY,
    input  logic [WIDTH-1:0]           xDATA,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_en,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic                       proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {RST, RUN} state_t;

    state_t           state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             push;
    logic             pop;
    logic             violation;

    assign READY     = (state == RUN) && (count != FULL);
    assign rx_valid  = (count != '0);
    assign rx_data   = mem[rd_ptr];
    assign rx_count  = count;
    assign push      = VALID && READY;
    assign pop       = rx_en && rx_valid;
    assign violation = hold_valid && (!VALID || (xDATA != hold_data));

    // storage array; contents need no reset since count gates visibility
    always_ff @(posedge ACLK) begin
        if (push)
            mem[wr_ptr] <= xDATA;
    end

    // control: state machine, pointers, occupancy and protocol monitor
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state      <= RST;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            proto_err  <= 1'b0;
        end else if (state == RST) begin
            state      <= RUN;
            hold_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            hold_valid <= VALID && !READY;
            hold_data  <= xDATA;
            if (violation)
                proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rx_channel.sv
// tb_rx_channel: directed scoreboard bench for rx_channel
module tb_rx_channel;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       valid = 1'b0;
    logic       ready;
    logic [7:0] data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_en = 1'b0;
    logic [2:0] rx_count;
    logic       proto_err;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] q[$];

    rx_channel #(.WIDTH(8), .DEPTH(4)) dut (
        .ACLK(clk), .ARESETn(rstn), .VALID(valid), .READY(ready), .xDATA(data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_en(rx_en),
        .rx_count(rx_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every pop the sink performs must return the oldest expected beat
    always @(negedge clk) begin
        if (rstn && rx_en && rx_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h expected no data", rx_data);
            end else begin
                check("rx_data_order", {24'h0, rx_data}, {24'h0, q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic pending;
        // 1: reset and release
        tick();
        tick();
        check("rst_ready", ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_count", rx_count, 0);
        check("rst_err", proto_err, 0);
        rstn = 1'b1;
        check("ready_rst_cycle", ready, 0);
        tick();
        check("ready_after_rst", ready, 1);
        // 2: single beat
        valid = 1'b1; data = 8'hA5; q.push_back(8'hA5);
        tick();
        valid = 1'b0;
        check("single_rx_valid", rx_valid, 1);
        check("single_count", rx_count, 1);
        check("single_data", rx_data, 8'hA5);
        rx_en = 1'b1;
        tick();
        rx_en = 1'b0;
        check("single_drain_count", rx_count, 0);
        check("single_drain_valid", rx_valid, 0);
        // 3: burst with backpressure and wrap
        valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data = 8'(i); q.push_back(8'(i));
            tick();
        end
        data = 8'h05; q.push_back(8'h05);
        check("full_count", rx_count, 4);
        check("full_ready", ready, 0);
        tick();
        check("full_stall_ready", ready, 0);
        rx_en = 1'b1;
        check("ready_pop_cycle", ready, 0);
        tick();
        rx_en = 1'b0;
        check("ready_after_pop", ready, 1);
        check("count_after_pop", rx_count, 3);
        tick();
        data = 8'h06; q.push_back(8'h06);
        check("refull_count", rx_count, 4);
        check("refull_ready", ready, 0);
        rx_en = 1'b1;
        pending = 1'b1;
        for (int n = 0; n < 40 && (q.size() != 0 || pending); n++) begin
            acc = valid && ready;
            tick();
            if (acc) begin
                valid = 1'b0;
                pending = 1'b0;
            end
        end
        rx_en = 1'b0;
        check("burst_drained_count", rx_count, 0);
        check("burst_scoreboard_empty", q.size(), 0);
        check("burst_no_err", proto_err, 0);
        // 4: full-rate streaming
        valid = 1'b1; rx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data = 8'h10 + 8'(i); q.push_back(8'h10 + 8'(i));
            check("stream_ready", ready, 1);
            tick();
            check("stream_count", rx_count, 1);
        end
        valid = 1'b0;
        tick();
        rx_en = 1'b0;
        check("stream_drained", rx_count, 0);
        check("stream_scoreboard_empty", q.size(), 0);
        // 5a: data change while stalled
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 8'h20 + 8'(i); q.push_back(8'h20 + 8'(i));
            tick();
        end
        data = 8'h33;
        tick();
        check("err_before_change", proto_err, 0);
        data = 8'h34;
        tick();
        valid = 1'b0;
        check("err_data_change", proto_err, 1);
        tick();
        check("err_sticky", proto_err, 1);
        rx_en = 1'b1;
        repeat (4) tick();
        rx_en = 1'b0;
        check("err_drain_count", rx_count, 0);
        check("err_sticky_after_drain", proto_err, 1);
        // 5b: VALID dropped before READY
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("err_cleared", proto_err, 0);
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 8'h40 + 8'(i);
            tick();
        end
        q.push_back(8'h40);
        data = 8'h55;
        tick();
        valid = 1'b0;
        tick();
        check("err_valid_drop", proto_err, 1);
        rx_en = 1'b1;
        tick();
        rx_en = 1'b0;
        check("three_buffered", rx_count, 3);
        // 6: mid-operation reset with in-flight beat
        valid = 1'b1; data = 8'h77;
        rstn = 1'b0;
        tick();
        check("midrst_count", rx_count, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_ready", ready, 0);
        check("midrst_err", proto_err, 0);
        rstn = 1'b1;
        check("midrst_ready_rst_cycle", ready, 0);
        tick();
        valid = 1'b0;
        check("midrst_no_accept", rx_count, 0);
        check("midrst_ready_run", ready, 1);
        check("midrst_err_run", proto_err, 0);
        valid = 1'b1; data = 8'h88; q.push_back(8'h88);
        tick();
        valid = 1'b0;
        check("refill_count", rx_count, 1);
        check("refill_data", rx_data, 8'h88);
        rx_en = 1'b1;
        tick();
        rx_en = 1'b0;
        check("refill_drained", rx_count, 0);
        check("final_scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
